alu_ctrl: RTL and testbench

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl.sv | 106 ++++++++++
 tb/tb_alu_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl.sv
// Command sequencer for a registered ALU: accepts one command, drives the ALU
// for one cycle, captures its result into the accumulator and a held response.
module alu_ctrl #(
  parameter int WORD_SIZE = 32,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [WORD_SIZE-1:0] cmd_a,
  input  logic [WORD_SIZE-1:0] cmd_b,
  input  logic                 cmd_use_acc,
  input  logic [TAG_WIDTH-1:0] cmd_tag,
  output logic [2:0]           alu_op,
  output logic [WORD_SIZE-1:0] alu_in1,
  output logic [WORD_SIZE-1:0] alu_in2,
  output logic                 alu_enable,
  input  logic [WORD_SIZE-1:0] alu_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WORD_SIZE-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0] rsp_tag,
  output logic                 busy,
  output logic [15:0]          op_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]           r_state;
  logic [2:0]           r_op;
  logic [WORD_SIZE-1:0] r_in1;
  logic [WORD_SIZE-1:0] r_in2;
  logic [WORD_SIZE-1:0] r_acc;
  logic [TAG_WIDTH-1:0] r_tag;
  logic                 r_rsp_valid;
  logic [WORD_SIZE-1:0] r_rsp_data;
  logic [TAG_WIDTH-1:0] r_rsp_tag;
  logic [15:0]          r_op_count;

  logic w_accept;
  logic w_done;

  // Ready is suppressed while reset is held even though the state is IDLE.
  assign cmd_ready  = (r_state == S_IDLE) && !rst;
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_done     = r_rsp_valid && rsp_ready;

  assign busy       = (r_state != S_IDLE);
  assign alu_enable = (r_state == S_ISSUE);
  assign alu_op     = r_op;
  assign alu_in1    = r_in1;
  assign alu_in2    = r_in2;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_tag    = r_rsp_tag;
  assign op_count   = r_op_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_in1       <= '0;
      r_in2       <= '0;
      r_acc       <= '0;
      r_tag       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_tag   <= '0;
      r_op_count  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= cmd_op;
            r_tag   <= cmd_tag;
            r_in1   <= cmd_use_acc ? r_acc : cmd_a;
            r_in2   <= cmd_b;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          r_rsp_data  <= alu_out;
          r_acc       <= alu_out;
          r_rsp_tag   <= r_tag;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (w_done) begin
            r_rsp_valid <= 1'b0;
            r_op_count  <= r_op_count + 16'd1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: registered ALU stand-in plus a per-command
// reference model of result, accumulator and completion count.
module tb_alu_ctrl;

  localparam int W = 32;
  localparam int T = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = '0;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic         cmd_use_acc = 1'b0;
  logic [T-1:0] cmd_tag = '0;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_in1;
  logic [W-1:0] alu_in2;
  logic         alu_enable;
  logic [W-1:0] alu_out;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_data;
  logic [T-1:0] rsp_tag;
  logic         busy;
  logic [15:0]  op_count;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] m_acc = '0;
  logic [15:0]  m_cnt = '0;
  logic         prev_en = 1'b0;

  alu_ctrl #(.WORD_SIZE(W), .TAG_WIDTH(T)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_use_acc(cmd_use_acc), .cmd_tag(cmd_tag),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_enable(alu_enable), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 SLT, 4 AND, 5 OR, 6 XOR, 7 SHIFT(left)
  function automatic logic [W-1:0] alu_fn(input logic [2:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a * b;
      3'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4: return a & b;
      3'd5: return a | b;
      3'd6: return a ^ b;
      default: return a << b[4:0];
    endcase
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) alu_out <= '0;
    else if (alu_enable) alu_out <= alu_fn(alu_op, alu_in1, alu_in2);

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (prev_en) chk("en_single_pulse", alu_enable, 0);
    prev_en = alu_enable;
  end

  // Entered and left at a negedge with the DUT in IDLE.
  task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic use_acc,
                         input logic [T-1:0] tag, input int stall);
    logic [W-1:0] in1;
    logic [W-1:0] exp;
    in1 = use_acc ? m_acc : a;
    exp = alu_fn(op, in1, b);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_op = op; cmd_a = a; cmd_b = b;
    cmd_use_acc = use_acc; cmd_tag = tag;
    @(negedge clk);
    cmd_valid = 0; cmd_a = $urandom; cmd_b = $urandom;
    cmd_op = 3'($urandom); cmd_tag = 4'($urandom);
    chk("issue_en", alu_enable, 1);
    chk("issue_op", alu_op, op);
    chk("issue_in1", alu_in1, in1);
    chk("issue_in2", alu_in2, b);
    chk("issue_busy", busy, 1);
    chk("issue_ready", cmd_ready, 0);
    @(negedge clk);
    chk("wait_en", alu_enable, 0);
    chk("wait_rspv", rsp_valid, 0);
    chk("wait_in1_hold", alu_in1, in1);
    @(negedge clk);
    chk("resp_valid", rsp_valid, 1);
    chk("resp_data", rsp_data, exp);
    chk("resp_tag", rsp_tag, tag);
    m_acc = exp;
    if (stall > 0) begin
      rsp_ready = 0;
      cmd_valid = 1;
      repeat (stall) begin
        @(negedge clk);
        chk("stall_valid", rsp_valid, 1);
        chk("stall_data", rsp_data, exp);
        chk("stall_tag", rsp_tag, tag);
        chk("stall_ready", cmd_ready, 0);
        chk("stall_en", alu_enable, 0);
        chk("stall_in2_hold", alu_in2, b);
      end
      cmd_valid = 0;
      rsp_ready = 1;
    end
    @(negedge clk);
    m_cnt = m_cnt + 16'd1;
    chk("done_rspv", rsp_valid, 0);
    chk("done_count", op_count, m_cnt);
    chk("done_busy", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_en", alu_enable, 0);
    rst = 0;
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", op_count, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_tag", rsp_tag, 0);
    chk("rst_in1", alu_in1, 0);
    chk("rst_op", alu_op, 0);

    run_cmd(3'd0, 5, 7, 0, 4'd3, 0);
    chk("add_result_acc", m_acc, 12);
    run_cmd(3'd1, 10, 3, 0, 4'd1, 0);
    run_cmd(3'd2, 32'hDEAD, 4, 1, 4'd2, 0);
    chk("mul_acc_28", m_acc, 28);
    run_cmd(3'd6, 32'h55, 32'hF0, 0, 4'd9, 5);

    // Reset arriving while the command sits in WAIT
    cmd_valid = 1; cmd_op = 3'd0; cmd_a = 100; cmd_b = 1;
    cmd_use_acc = 0; cmd_tag = 4'd7;
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    rst = 1;
    #2;
    chk("mid_rspv", rsp_valid, 0);
    chk("mid_en", alu_enable, 0);
    chk("mid_count", op_count, 0);
    chk("mid_busy", busy, 0);
    chk("mid_in1", alu_in1, 0);
    rst = 0;
    m_acc = '0;
    m_cnt = '0;
    @(negedge clk);
    chk("mid_no_rsp", rsp_valid, 0);
    run_cmd(3'd0, 32'h1234, 6, 1, 4'd5, 0);
    chk("acc_after_rst", m_acc, 6);

    run_cmd(3'd3, 2, 9, 0, 4'd4, 0);
    chk("slt_one", m_acc, 1);
    run_cmd(3'd7, 1, 4, 0, 4'd8, 0);
    chk("shift_16", m_acc, 16);
    run_cmd(3'd3, 32'hFFFF_FFFE, 1, 0, 4'd6, 1);

    for (int i = 0; i < 40; i++) begin
      run_cmd(3'($urandom), $urandom, $urandom, 1'($urandom),
              4'($urandom), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) begin
        rsp_ready = 1'($urandom);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        chk("idle_rspv", rsp_valid, 0);
        rsp_ready = 1;
      end
    end

    force dut.r_op_count = 16'hFFFF;
    #1;
    release dut.r_op_count;
    m_cnt = 16'hFFFF;
    @(negedge clk);
    run_cmd(3'd4, 32'hF0F0, 32'hFF00, 0, 4'd15, 0);
    chk("count_wrap", op_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
